// File: rtl/ir_wand_tx.sv
// Wand-side IR transmitter: sends a 16-bit code as a carrier-modulated,
// pulse-distance framed burst with a send/busy/done handshake.
module ir_wand_tx #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658,
  parameter int GAP_UNITS    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [15:0] data,
  output logic        busy,
  output logic        done,
  output logic        ir_mark,
  output logic        ir_led
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LEAD_MARK  = 3'd1;
  localparam logic [2:0] S_LEAD_SPACE = 3'd2;
  localparam logic [2:0] S_BIT_MARK   = 3'd3;
  localparam logic [2:0] S_BIT_SPACE  = 3'd4;
  localparam logic [2:0] S_STOP_MARK  = 3'd5;
  localparam logic [2:0] S_GAP        = 3'd6;

  localparam int UNIT_W    = $clog2(UNIT_CYCLES + 1);
  localparam int CAR_W     = $clog2(CARRIER_HALF + 1);
  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UNITS_W   = $clog2(MAX_UNITS + 1);

  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_HALF - 1);

  logic [2:0]         state, state_nxt;
  logic [UNIT_W-1:0]  unit_cnt;
  logic [UNITS_W-1:0] units_cnt, units_tgt;
  logic [3:0]         bit_idx;
  logic [15:0]        shreg;
  logic [CAR_W-1:0]   car_cnt;
  logic               car_phase;
  logic               state_end;

  function automatic logic is_mark(input logic [2:0] s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

  // Length of the current state in protocol units; a bit space encodes the
  // pending LSB of the shift register.
  always_comb begin
    units_tgt = '0;
    case (state)
      S_LEAD_MARK:  units_tgt = UNITS_W'(16);
      S_LEAD_SPACE: units_tgt = UNITS_W'(8);
      S_BIT_MARK:   units_tgt = UNITS_W'(1);
      S_BIT_SPACE:  units_tgt = shreg[0] ? UNITS_W'(3) : UNITS_W'(1);
      S_STOP_MARK:  units_tgt = UNITS_W'(1);
      S_GAP:        units_tgt = UNITS_W'(GAP_UNITS);
      default:      units_tgt = '0;
    endcase
  end

  assign state_end = (state != S_IDLE) && (unit_cnt == UNIT_LAST) &&
                     (units_cnt == units_tgt - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (send) state_nxt = S_LEAD_MARK;
      S_LEAD_MARK:  if (state_end) state_nxt = S_LEAD_SPACE;
      S_LEAD_SPACE: if (state_end) state_nxt = S_BIT_MARK;
      S_BIT_MARK:   if (state_end) state_nxt = S_BIT_SPACE;
      S_BIT_SPACE:  if (state_end) state_nxt = (bit_idx == 4'd15) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (state_end) state_nxt = S_GAP;
      S_GAP:        if (state_end) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      unit_cnt  <= '0;
      units_cnt <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      car_cnt   <= '0;
      car_phase <= 1'b1;
    end else begin
      state <= state_nxt;
      done  <= (state == S_GAP) && state_end;

      if ((state == S_IDLE) && send) begin
        shreg   <= data;
        bit_idx <= '0;
      end else if ((state == S_BIT_SPACE) && state_end) begin
        shreg   <= shreg >> 1;
        bit_idx <= bit_idx + 4'd1;
      end

      if ((state == S_IDLE) || state_end) begin
        unit_cnt  <= '0;
        units_cnt <= '0;
      end else if (unit_cnt == UNIT_LAST) begin
        unit_cnt  <= '0;
        units_cnt <= units_cnt + 1'b1;
      end else begin
        unit_cnt <= unit_cnt + 1'b1;
      end

      // Carrier only free-runs while staying inside a mark, so every mark
      // begins at phase 1 with a fresh half-period.
      if (is_mark(state) && is_mark(state_nxt)) begin
        if (car_cnt == CAR_LAST) begin
          car_cnt   <= '0;
          car_phase <= ~car_phase;
        end else begin
          car_cnt <= car_cnt + 1'b1;
        end
      end else begin
        car_cnt   <= '0;
        car_phase <= 1'b1;
      end
    end
  end

  assign busy    = (state != S_IDLE);
  assign ir_mark = is_mark(state);
  assign ir_led  = ir_mark & car_phase;

endmodule

// File: tb/tb_ir_wand_tx.sv
// Bench for ir_wand_tx: table of frames plus hand sequences, each cycle
// compared against a waveform built from the frame-format rules.
module tb_ir_wand_tx;

  localparam int UC  = 4;
  localparam int CH  = 1;
  localparam int GAP = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        send  = 1'b0;
  logic [15:0] data  = '0;
  logic        busy, done, ir_mark, ir_led;

  int checks = 0;
  int errors = 0;

  bit exp_mark[$];
  bit exp_led[$];

  ir_wand_tx #(.UNIT_CYCLES(UC), .CARRIER_HALF(CH), .GAP_UNITS(GAP)) dut (
    .clock(clock), .reset(reset), .send(send), .data(data),
    .busy(busy), .done(done), .ir_mark(ir_mark), .ir_led(ir_led)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_run(input bit m, input int units);
    for (int j = 0; j < units * UC; j++) begin
      exp_mark.push_back(m);
      exp_led.push_back(m && ((j % (2 * CH)) < CH));
    end
  endfunction

  function automatic void build(input logic [15:0] d);
    exp_mark.delete();
    exp_led.delete();
    add_run(1'b1, 16);
    add_run(1'b0, 8);
    for (int i = 0; i < 16; i++) begin
      add_run(1'b1, 1);
      add_run(1'b0, d[i] ? 3 : 1);
    end
    add_run(1'b1, 1);
    add_run(1'b0, GAP);
  endfunction

  // Normal launch waits an idle cycle first; b2b launches on the current
  // (done) cycle.
  task automatic launch(input logic [15:0] d, input bit b2b);
    if (!b2b) begin
      @(negedge clock);
      chk("idle_done_low", done, 1'b0);
      chk("idle_busy_low", busy, 1'b0);
    end
    send = 1'b1;
    data = d;
    @(posedge clock);
    #1;
    send = 1'b0;
    data = 16'($urandom);
  endtask

  // Follows one frame cycle by cycle; returns on the negedge where busy fell.
  task automatic watch(input logic [15:0] d, input int exp_len, input bit mid_send);
    int len = 0;
    int space_len = 0;
    int nbit = 0;
    bit prev_mark = 1'b0;
    logic [15:0] decoded = '0;
    build(d);
    @(negedge clock);
    while (busy === 1'b1 && len < 2000) begin
      if (len < exp_mark.size()) begin
        chk($sformatf("mark[%0d]", len), ir_mark, exp_mark[len]);
        chk($sformatf("led[%0d]", len), ir_led, exp_led[len]);
      end
      chk("done_in_frame", done, 1'b0);
      if (ir_mark === 1'b1) begin
        if (!prev_mark && len > 0 && space_len != 8 * UC) begin
          if (nbit < 16) decoded[nbit] = (space_len > 2 * UC);
          nbit++;
        end
        space_len = 0;
      end else begin
        space_len++;
      end
      prev_mark = (ir_mark === 1'b1);
      if (mid_send && len == 100) begin
        send = 1'b1;
        data = 16'h1234;
      end else if (mid_send && len == 101) begin
        send = 1'b0;
      end
      len++;
      @(negedge clock);
    end
    chk("busy_len", len, exp_len);
    chk("model_len", len, exp_mark.size());
    chk("decoded_bits", decoded, d);
    chk("decoded_count", nbit, 16);
    chk("done_pulse", done, 1'b1);
    chk("led_after", ir_led, 1'b0);
  endtask

  typedef struct {
    logic [15:0] d;
    int          len;
    bit          mid_send;
    bit          b2b;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{d: 16'h0000, len: 236, mid_send: 1'b0, b2b: 1'b0};
    vecs[1] = '{d: 16'h0001, len: 244, mid_send: 1'b0, b2b: 1'b0};
    vecs[2] = '{d: 16'hFFFF, len: 364, mid_send: 1'b1, b2b: 1'b0};
    vecs[3] = '{d: 16'hA5A5, len: 300, mid_send: 1'b0, b2b: 1'b1};

    // Reset held with send asserted starts nothing
    @(negedge clock);
    reset = 1'b1;
    send  = 1'b1;
    data  = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mark", ir_mark, 1'b0);
      chk("rst_led", ir_led, 1'b0);
    end
    send  = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_mark", ir_mark, 1'b0);
    end

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].d, vecs[v].b2b);
      watch(vecs[v].d, vecs[v].len, vecs[v].mid_send);
    end
    @(negedge clock);
    chk("done_single_cycle", done, 1'b0);

    // Reset during the mark of bit 5 of an all-zero frame
    launch(16'h0000, 1'b0);
    repeat (138) @(negedge clock);
    chk("pre_rst_mark", ir_mark, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mark", ir_mark, 1'b0);
    chk("midrst_led", ir_led, 1'b0);
    chk("midrst_done", done, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("midrst_no_done", done, 1'b0);
      chk("midrst_idle", busy, 1'b0);
    end
    launch(16'h00FF, 1'b0);
    watch(16'h00FF, 300, 1'b0);

    // Random codes against the rule-based model
    for (int r = 0; r < 4; r++) begin
      logic [15:0] d;
      d = 16'($urandom);
      launch(d, 1'b0);
      watch(d, UC * (57 + 2 * $countones(d) + GAP), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
